ring_decode: RTL and testbench

RING_DECODE -- requirements
Module: ring_decode

---
 rtl/ring_decode_if.sv | 24 ++
 rtl/ring_decode.sv | 104 ++++++++++
 tb/tb_ring_decode.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ring_decode_if.sv
// Bus bundle for ring_decode: the ring word handshake and all decoded status outputs.
// clk and clear are kept as plain ports on the decoder.
interface ring_decode_if;
    logic [4:0] ring_in;
    logic       valid_in;
    logic       resync;
    logic       locked;
    logic       err;
    logic [4:0] ref_pat;
    logic [2:0] ones;
    logic [2:0] step;
    logic       turn;
    logic [3:0] miss_cnt;

    modport master (
        output ring_in, valid_in, resync,
        input  locked, err, ref_pat, ones, step, turn, miss_cnt
    );

    modport slave (
        input  ring_in, valid_in, resync,
        output locked, err, ref_pat, ones, step, turn, miss_cnt
    );
endinterface

// File: rtl/ring_decode.sv
// Ring-word decoder: locks onto a 5-bit reference pattern and tracks its left rotation.
// Define RING_DECODE_AUTOSYNC_EN to let a valid nonzero word relock straight out of ERROR.
//
// state | meaning
// IDLE  | no reference held, waiting for a valid nonzero word
// LOCK  | reference held, each valid word must be the rotate-left of the previous one
// ERROR | rotation broken, counting further valid words as misses
module ring_decode (
    input logic          clk,
    input logic          clear,
    ring_decode_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOCK, ERROR} state_t;

    state_t     state;
    logic [4:0] prev;
    logic [4:0] expected;
    logic [2:0] word_ones;
    logic       word_nonzero;
    logic       may_capture;
    logic       do_capture;
    logic [3:0] miss_next;

    function automatic logic [2:0] popcount5(input logic [4:0] w);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n = n + {2'b00, w[i]};
        end
        return n;
    endfunction

    assign expected     = {prev[3:0], prev[4]};
    assign word_ones    = popcount5(bus.ring_in);
    assign word_nonzero = |bus.ring_in;
    assign miss_next    = (bus.miss_cnt == 4'd15) ? 4'd15 : bus.miss_cnt + 4'd1;

`ifdef RING_DECODE_AUTOSYNC_EN
    assign may_capture = bus.resync || (state == IDLE) || (state == ERROR);
`else
    assign may_capture = bus.resync || (state == IDLE);
`endif

    // A capture takes precedence over the plain resync clear on the same edge.
    assign do_capture = bus.valid_in && word_nonzero && may_capture;

    always_ff @(posedge clk) begin
        if (!clear) begin
            state        <= IDLE;
            prev         <= 5'd0;
            bus.locked   <= 1'b0;
            bus.err      <= 1'b0;
            bus.ref_pat  <= 5'd0;
            bus.ones     <= 3'd0;
            bus.step     <= 3'd0;
            bus.turn     <= 1'b0;
            bus.miss_cnt <= 4'd0;
        end else begin
            bus.turn <= 1'b0;
            if (do_capture) begin
                state       <= LOCK;
                prev        <= bus.ring_in;
                bus.ref_pat <= bus.ring_in;
                bus.ones    <= word_ones;
                bus.step    <= 3'd0;
                bus.locked  <= 1'b1;
            end else if (bus.resync) begin
                state       <= IDLE;
                prev        <= 5'd0;
                bus.ref_pat <= 5'd0;
                bus.ones    <= 3'd0;
                bus.step    <= 3'd0;
                bus.locked  <= 1'b0;
            end else if (bus.valid_in) begin
                case (state)
                    LOCK: begin
                        if (bus.ring_in == expected) begin
                            prev <= bus.ring_in;
                            if (bus.step == 3'd4) begin
                                bus.step <= 3'd0;
                                bus.turn <= 1'b1;
                            end else begin
                                bus.step <= bus.step + 3'd1;
                            end
                        end else begin
                            state        <= ERROR;
                            bus.locked   <= 1'b0;
                            bus.err      <= 1'b1;
                            bus.miss_cnt <= miss_next;
                        end
                    end
                    ERROR: begin
                        bus.miss_cnt <= miss_next;
                    end
                    default: begin
                        // IDLE with an all-zero word: nothing to capture.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_decode.sv
// Scoreboard bench for ring_decode: directed scenarios plus random traffic checked
// against a rotation-level reference model; the monitor compares every cycle's outputs.
module tb_ring_decode;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic [4:0] ref_pat;
        logic [2:0] ones;
        logic [2:0] step;
        logic       turn;
        logic [3:0] miss_cnt;
    } exp_t;

    typedef enum int {M_IDLE, M_LOCK, M_ERROR} mode_t;

    logic clk;
    logic clear;
    ring_decode_if bus();

    ring_decode dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    mode_t      m_mode;
    logic [4:0] m_ref;
    logic [4:0] m_prev;
    int         m_step;
    bit         m_err;
    int         m_miss;

    function automatic logic [4:0] rotl(input logic [4:0] w);
        logic [9:0] d;
        d = {w, w};
        return d[8:4];
    endfunction

    function automatic void m_capture(input logic [4:0] w);
        m_mode = M_LOCK;
        m_ref  = w;
        m_prev = w;
        m_step = 0;
    endfunction

    function automatic void m_miss_inc();
        if (m_miss < 15) m_miss++;
    endfunction

    // Advances the model by one clock edge and queues what the outputs must show afterwards.
    task automatic drive(input bit c, input bit v, input bit r, input logic [4:0] w);
        bit   autosync;
        bit   turn;
        exp_t e;
`ifdef RING_DECODE_AUTOSYNC_EN
        autosync = 1'b1;
`else
        autosync = 1'b0;
`endif
        @(negedge clk);
        clear        = c;
        bus.valid_in = v;
        bus.resync   = r;
        bus.ring_in  = w;
        turn = 1'b0;
        if (!c) begin
            m_mode = M_IDLE; m_ref = 0; m_prev = 0; m_step = 0; m_err = 0; m_miss = 0;
        end else if (r) begin
            m_mode = M_IDLE; m_ref = 0; m_prev = 0; m_step = 0;
            if (v && w != 0) m_capture(w);
        end else if (v) begin
            if (m_mode == M_IDLE) begin
                if (w != 0) m_capture(w);
            end else if (m_mode == M_LOCK) begin
                if (w == rotl(m_prev)) begin
                    m_prev = w;
                    m_step = (m_step + 1) % 5;
                    turn   = (m_step == 0);
                end else begin
                    m_mode = M_ERROR;
                    m_err  = 1'b1;
                    m_miss_inc();
                end
            end else begin
                if (autosync && w != 0) m_capture(w);
                else m_miss_inc();
            end
        end
        e.locked   = (m_mode == M_LOCK);
        e.err      = m_err;
        e.ref_pat  = m_ref;
        e.ones     = 3'($countones(m_ref));
        e.step     = 3'(m_step);
        e.turn     = turn;
        e.miss_cnt = 4'(m_miss);
        exp_q.push_back(e);
    endtask

    task automatic word(input logic [4:0] w);
        drive(1'b1, 1'b1, 1'b0, w);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.locked, bus.err, bus.ref_pat, bus.ones, bus.step, bus.turn, bus.miss_cnt};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got locked=%b err=%b ref=%b ones=%0d step=%0d turn=%b miss=%0d want locked=%b err=%b ref=%b ones=%0d step=%0d turn=%b miss=%0d",
                             $time, a.locked, a.err, a.ref_pat, a.ones, a.step, a.turn, a.miss_cnt,
                             e.locked, e.err, e.ref_pat, e.ones, e.step, e.turn, e.miss_cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        logic [4:0] seq[6];
        int         r;
        logic [4:0] w;
        clear        = 1'b0;
        bus.valid_in = 1'b0;
        bus.resync   = 1'b0;
        bus.ring_in  = 5'd0;
        m_mode = M_IDLE; m_ref = 0; m_prev = 0; m_step = 0; m_err = 0; m_miss = 0;

        drive(1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0);

        seq = '{5'b00110, 5'b01100, 5'b11000, 5'b10001, 5'b00011, 5'b00110};
        foreach (seq[i]) word(seq[i]);

        word(5'b01110);
        word(5'b00011);
        drive(1'b1, 1'b0, 1'b0, 5'b11111);
        word(5'b10101);
        word(5'b00000);
        for (int i = 0; i < 14; i++) word(5'b00000);

        drive(1'b1, 1'b1, 1'b1, 5'b10000);
        word(5'b00010);
        word(5'b00101);

        drive(1'b1, 1'b0, 1'b1, 5'b00000);
        word(5'b00000);
        word(5'b00001);
        word(5'b00010);

        drive(1'b1, 1'b1, 1'b1, 5'b11111);
        for (int i = 0; i < 6; i++) word(5'b11111);
        drive(1'b1, 1'b1, 1'b1, 5'b00000);

        word(5'b01001);
        word(5'b10010);
        drive(1'b0, 1'b1, 1'b1, 5'b00101);
        drive(1'b1, 1'b0, 1'b0, 5'd0);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 99) < 65 && m_mode == M_LOCK) w = rotl(m_prev);
            else if ($urandom_range(0, 9) == 0) w = 5'd0;
            else w = 5'($urandom_range(0, 31));
            drive(r >= 2, $urandom_range(0, 99) < 75, r >= 2 && r < 9, w);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
